fifo_module: RTL and testbench

FIFO_MODULE -- requirements
Module: fifo_module

---
 rtl/fifo_module.sv | 100 ++++++++++
 tb/tb_fifo_module.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fifo_module.sv
// ============================================================================
// Module   : fifo_module
// Purpose  : Single-clock FIFO with registered read data and registered
//            full/empty flags. Define FIFO_MODULE_COUNT_EN to add count_out.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_module #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                       clk_put,
    input  logic                       reset,
    input  logic                       req_put,
    input  logic                       req_get,
    input  logic [DATA_W-1:0]          data_put,
    output logic [DATA_W-1:0]          data_get,
    output logic                       full_out,
`ifdef FIFO_MODULE_COUNT_EN
    output logic                       empty_out,
    output logic [$clog2(DEPTH):0]     count_out
`else
    output logic                       empty_out
`endif
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W:0]   head_q, head_d;
    logic [ADDR_W:0]   tail_q, tail_d;
    logic [DATA_W-1:0] data_get_q;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              put_acc;
    logic              get_acc;

    // Acceptance is judged against the registered flags, so a put while full
    // is dropped even if a get frees a slot at the same edge (and vice versa).
    assign put_acc = req_put & ~full_q;
    assign get_acc = req_get & ~empty_q;

    always_comb begin
        head_d  = get_acc ? head_q + PTR_ONE : head_q;
        tail_d  = put_acc ? tail_q + PTR_ONE : tail_q;
        empty_d = (head_d == tail_d);
        full_d  = (head_d[ADDR_W-1:0] == tail_d[ADDR_W-1:0]) &&
                  (head_d[ADDR_W] != tail_d[ADDR_W]);
    end

    always_ff @(posedge clk_put or posedge reset) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            data_get_q <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            if (get_acc) begin
                data_get_q <= mem_q[head_q[ADDR_W-1:0]];
            end
        end
    end

    // Storage needs no reset; pointers alone define which words are live.
    always_ff @(posedge clk_put) begin
        if (put_acc) begin
            mem_q[tail_q[ADDR_W-1:0]] <= data_put;
        end
    end

`ifdef FIFO_MODULE_COUNT_EN
    logic [ADDR_W:0] count_q, count_d;

    assign count_d = tail_d - head_d;

    always_ff @(posedge clk_put or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out = count_q;
`endif

    assign data_get  = data_get_q;
    assign full_out  = full_q;
    assign empty_out = empty_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_module.sv
// ============================================================================
// Module   : tb_fifo_module
// Purpose  : Scoreboard bench for fifo_module with directed vectors.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fifo_module;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int NSTREAM = 44100;

    logic              clk_put = 1'b0;
    logic              reset   = 1'b1;
    logic              req_put = 1'b0;
    logic              req_get = 1'b0;
    logic [DATA_W-1:0] data_put = '0;
    logic [DATA_W-1:0] data_get;
    logic              full_out;
    logic              empty_out;
`ifdef FIFO_MODULE_COUNT_EN
    logic [3:0]        count_out;
`endif

    fifo_module #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk_put   (clk_put),
        .reset     (reset),
        .req_put   (req_put),
        .req_get   (req_get),
        .data_put  (data_put),
        .data_get  (data_get),
        .full_out  (full_out),
`ifdef FIFO_MODULE_COUNT_EN
        .empty_out (empty_out),
        .count_out (count_out)
`else
        .empty_out (empty_out)
`endif
    );

    always #5 clk_put = ~clk_put;

    typedef struct {
        string             name;
        logic [DATA_W-1:0] dg;
        logic              f;
        logic              e;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: each edge's outcome is compared against the expectation that
    // the driver queued when it presented the inputs for that edge.
    always @(posedge clk_put) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.name, ".data_get"},  data_get, e.dg);
            chk({e.name, ".full_out"},  {31'd0, full_out},  {31'd0, e.f});
            chk({e.name, ".empty_out"}, {31'd0, empty_out}, {31'd0, e.e});
        end
    end

    task automatic step(input string nm, input logic p, input logic g,
                        input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] edg,
                        input logic ef, input logic ee);
        exp_t x;
        @(negedge clk_put);
        req_put  = p;
        req_get  = g;
        data_put = d;
        x.name = nm; x.dg = edg; x.f = ef; x.e = ee;
        exp_q.push_back(x);
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk_put);
        req_put = 1'b0;
        req_get = 1'b0;
        while (exp_q.size() > 0 && n < 10) begin
            @(negedge clk_put);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        // Reset and idle
        repeat (2) @(negedge clk_put);
        chk("rst.data_get",  data_get, 32'h0);
        chk("rst.empty_out", {31'd0, empty_out}, 32'h1);
        chk("rst.full_out",  {31'd0, full_out},  32'h0);
`ifdef FIFO_MODULE_COUNT_EN
        chk("rst.count_out", {28'd0, count_out}, 32'h0);
`endif
        reset = 1'b0;
        step("idle", 0, 0, 32'h0, 32'h0, 0, 1);

        // Three writes then three reads
        step("w1", 1, 0, 32'h1, 32'h0, 0, 0);
        step("w2", 1, 0, 32'h2, 32'h0, 0, 0);
        step("w3", 1, 0, 32'h3, 32'h0, 0, 0);
        step("r1", 0, 1, 32'h0, 32'h1, 0, 0);
        step("r2", 0, 1, 32'h0, 32'h2, 0, 0);
        step("r3", 0, 1, 32'h0, 32'h3, 0, 1);
        step("hold",     0, 0, 32'h0, 32'h3, 0, 1);
        step("getempty", 0, 1, 32'h0, 32'h3, 0, 1);

        // Fill to DEPTH, overflow attempt, then full put+get collision
        for (int i = 0; i < DEPTH; i++)
            step("fill", 1, 0, 32'h10 + i, 32'h3, (i == DEPTH - 1), 0);
        step("ovf",     1, 0, 32'hDEAD, 32'h3,  1, 0);
        step("fullpg",  1, 1, 32'hAA,   32'h10, 0, 0);
        for (int i = 1; i < DEPTH; i++)
            step("rdall", 0, 1, 32'h0, 32'h10 + i, 0, (i == DEPTH - 1));

        // Empty put+get collision: put only, no bypass
        step("emptypg", 1, 1, 32'hAA, 32'h17, 0, 0);
        step("rdaa",    0, 1, 32'h0,  32'hAA, 0, 1);

        // Continuous streaming across many pointer wraps
        for (int k = 0; k < NSTREAM; k++)
            step("stream", 1, 1, 32'h1000 + k,
                 (k == 0) ? 32'hAA : 32'h1000 + k - 1, 0, 0);
        step("streamlast", 0, 1, 32'h0, 32'h1000 + NSTREAM - 1, 0, 1);
        drain();

        // Reset mid-operation discards stored words
        for (int i = 0; i < 5; i++)
            step("pre_rst", 1, 0, 32'h50 + i, 32'h1000 + NSTREAM - 1, 0, 0);
        drain();
        reset = 1'b1;
        #1;
        chk("midrst.empty_out", {31'd0, empty_out}, 32'h1);
        chk("midrst.full_out",  {31'd0, full_out},  32'h0);
        chk("midrst.data_get",  data_get, 32'h0);
        @(negedge clk_put);
        reset = 1'b0;
        step("rd_after_rst", 0, 1, 32'h0,  32'h0,  0, 1);
        step("first_put",    1, 0, 32'h55, 32'h0,  0, 0);
        step("first_get",    0, 1, 32'h0,  32'h55, 0, 1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
